// File: rtl/boot_pkg.sv
// Shared types and defaults for the UART boot loader.
// Optional feature macro: BOOT_CHECKSUM_EN adds the CHECK state (trailer XOR byte).
package boot_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200 baud
    localparam int DEPTH_DEF        = 16;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        RECV,
        WRITE,
`ifdef BOOT_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } boot_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_state_e;

endpackage

// File: rtl/boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised rx, mid-bit sampling via a down-counter,
// false-start rejection, one-cycle rx_valid / rx_ferr pulses.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a low level
// RX_START | half-bit wait, then confirm start bit still low
// RX_DATA  | sample 8 data bits LSB first at mid-bit
// RX_STOP  | sample stop bit; high -> byte valid, low -> framing error
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_e      state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             tc;

    assign tc = (cnt_q == '0);

    // Synchroniser and receiver state registers; line resets to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Bit timing and framing: reload the down-counter at each bit, act on terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LD;
                end
            end
            RX_START: begin
                if (tc) begin
                    if (!rx_sync_q) begin
                        state_d   = RX_DATA;
                        cnt_d     = FULL_LD;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (tc) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (tc) begin
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_byte  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: header byte N, then N little-endian 32-bit words written to
// instruction memory; releases the CPU (cpu_rst_n high) only once the load completes.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailer byte equal to the XOR of
// the header and all payload bytes, checked in the CHECK state.
//
// state | meaning
// IDLE  | waiting for header byte
// COUNT | validate header N (0 or > DEPTH is an error)
// RECV  | collecting 4 bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// CHECK | waiting for trailer checksum byte (BOOT_CHECKSUM_EN only)
// DONE  | load complete, CPU released; sticky
// ERROR | bad header, framing or checksum error; sticky
module boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        restart,
    output logic        write,
    output logic [31:0] addr_in,
    output logic [31:0] data,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // One extra bit so the index can reach N == DEPTH without wrapping.
    localparam int IDX_W = $clog2(DEPTH) + 1;

    boot_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       hdr_q, hdr_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr)
    );

    // Loader state registers; reset drops any partially assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            hdr_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            hdr_q      <= hdr_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Next-state logic; restart overrides every state and clears all accumulators.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        hdr_d      = hdr_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (restart) begin
            state_d    = IDLE;
            idx_d      = '0;
            n_d        = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            hdr_d      = '0;
`ifdef BOOT_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_ferr) begin
                        state_d = ERROR;
                    end else if (rx_valid) begin
                        hdr_d   = rx_byte;
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = rx_byte;
`endif
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (hdr_q == 8'd0 || 32'(hdr_q) > 32'(DEPTH)) begin
                        state_d = ERROR;
                    end else begin
                        n_d        = IDX_W'(hdr_q);
                        idx_d      = '0;
                        byte_cnt_d = '0;
                        state_d    = RECV;
                    end
                end
                RECV: begin
                    if (rx_ferr) begin
                        state_d = ERROR;
                    end else if (rx_valid) begin
                        // Shift right so the first byte ends up in [7:0].
                        word_d = {rx_byte, word_q[31:8]};
`ifdef BOOT_CHECKSUM_EN
                        csum_d = csum_q ^ rx_byte;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_d = '0;
                            state_d    = WRITE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q + 1'b1 == n_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = RECV;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (rx_ferr) begin
                        state_d = ERROR;
                    end else if (rx_valid) begin
                        state_d = (rx_byte == csum_q) ? DONE : ERROR;
                    end
                end
`endif
                DONE:    state_d = DONE;
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            COUNT, RECV, WRITE: busy = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            CHECK:              busy = 1'b1;
`endif
            default:            busy = 1'b0;
        endcase
    end

    assign write     = (state_q == WRITE);
    assign addr_in   = 32'(idx_q);
    assign data      = word_q;
    assign cpu_rst_n = (state_q == DONE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERROR);

endmodule
